// File: rtl/id_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// id_pkg: ID-stage shared constants, writeback source enum, address mask.
// Rev 1.0
// ----------------------------------------------------------------------
package id_pkg;

`ifdef CONFIG_ISA_RV32E
    localparam int REG_N = 16;
`else
    localparam int REG_N = 32;
`endif
    localparam int REG_AW = $clog2(REG_N);

    localparam logic [4:0] C_ADDR_MASK = 5'(REG_N - 1);

    typedef enum logic {
        WB_EX  = 1'b0,
        WB_LSU = 1'b1
    } wb_src_t;

    function automatic logic [4:0] mask_addr(input logic [4:0] a);
        return a & C_ADDR_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_wb_rr_arb.sv
`default_nettype none
// ----------------------------------------------------------------------
// id_wb_rr_arb: two-requester round-robin arbiter (EX vs LSU).
// Rev 1.0
// ----------------------------------------------------------------------
module id_wb_rr_arb
    import id_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_req_ex,
    input  logic i_req_lsu,
    output logic o_gnt_ex,
    output logic o_gnt_lsu
);

    wb_src_t r_last;
    logic    w_gnt_ex;
    logic    w_gnt_lsu;

    // Under contention the source that lost last time wins.
    always_comb begin
        w_gnt_ex  = i_req_ex  & (~i_req_lsu | (r_last == WB_LSU));
        w_gnt_lsu = i_req_lsu & (~i_req_ex  | (r_last == WB_EX));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last <= WB_EX;
        end else if (w_gnt_ex) begin
            r_last <= WB_EX;
        end else if (w_gnt_lsu) begin
            r_last <= WB_LSU;
        end
    end

    assign o_gnt_ex  = w_gnt_ex;
    assign o_gnt_lsu = w_gnt_lsu;

endmodule
`default_nettype wire

// File: rtl/id_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// id_wb_arbiter: regfile write-port arbiter with pending-load scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------
module id_wb_arbiter
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ex_valid_i,
    input  logic [4:0]      ex_addr_i,
    input  logic [XLEN-1:0] ex_data_i,
    output logic            ex_ready_o,
    input  logic            lsu_valid_i,
    input  logic [4:0]      lsu_addr_i,
    input  logic [XLEN-1:0] lsu_data_i,
    output logic            lsu_ready_o,
    input  logic            pend_set_i,
    input  logic [4:0]      pend_addr_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            rd_wr_en_o,
    output logic [4:0]      rd_wr_addr_o,
    output logic [XLEN-1:0] rd_wr_data_o,
    output logic            err_o
);

    logic            w_gnt_ex;
    logic            w_gnt_lsu;
    logic            w_acc;
    logic [4:0]      w_acc_addr;
    logic [XLEN-1:0] w_acc_data;
    logic [4:0]      w_pend_addr;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_set;
    logic            w_clr;
    logic [REG_N-1:0] w_busy_nxt;
    logic            w_err_set;

    logic            r_wr_en;
    logic            r_wr_lsu;
    logic [4:0]      r_wr_addr;
    logic [XLEN-1:0] r_wr_data;
    logic [REG_N-1:0] r_busy;
    logic            r_err;

    id_wb_rr_arb u_arb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_req_ex  (ex_valid_i),
        .i_req_lsu (lsu_valid_i),
        .o_gnt_ex  (w_gnt_ex),
        .o_gnt_lsu (w_gnt_lsu)
    );

    assign ex_ready_o  = ex_valid_i  & w_gnt_ex;
    assign lsu_ready_o = lsu_valid_i & w_gnt_lsu;

    always_comb begin
        w_acc      = ex_ready_o | lsu_ready_o;
        w_acc_addr = lsu_ready_o ? mask_addr(lsu_addr_i) : mask_addr(ex_addr_i);
        w_acc_data = lsu_ready_o ? lsu_data_i : ex_data_i;
        w_pend_addr = mask_addr(pend_addr_i);
        w_rs1      = mask_addr(rs1_addr_i);
        w_rs2      = mask_addr(rs2_addr_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_en   <= 1'b0;
            r_wr_lsu  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en  <= w_acc & (w_acc_addr != 5'd0);
            r_wr_lsu <= lsu_ready_o & (w_acc_addr != 5'd0);
            if (w_acc) begin
                r_wr_addr <= w_acc_addr;
                r_wr_data <= w_acc_data;
            end
        end
    end

    // Set is applied after clear so a new load to a committing register wins.
    always_comb begin
        w_set      = pend_set_i & (w_pend_addr != 5'd0);
        w_clr      = r_wr_en & r_wr_lsu;
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[r_wr_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[w_pend_addr] = 1'b1;
        end
        w_err_set = w_set & r_busy[w_pend_addr] &
                    ~(w_clr & (r_wr_addr == w_pend_addr));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err | w_err_set;
        end
    end

    always_comb begin
        rs1_busy_o = (w_rs1 != 5'd0) &
                     (r_busy[w_rs1] | (r_wr_en & (r_wr_addr == w_rs1)));
        rs2_busy_o = (w_rs2 != 5'd0) &
                     (r_busy[w_rs2] | (r_wr_en & (r_wr_addr == w_rs2)));
    end

    assign rd_wr_en_o   = r_wr_en;
    assign rd_wr_addr_o = r_wr_addr;
    assign rd_wr_data_o = r_wr_data;
    assign err_o        = r_err;

endmodule
`default_nettype wire
